// File: rtl/pio_osr_pkg.sv
// Shared types for the PIO output shift register.
//   fifo_status  : TX fifo empty/full flags
//   osr_state_t  : OSR_IDLE (accepting requests), OSR_LOAD (pop issued, capture pending)
//   OSR_W        : shift register width
package pio_osr_pkg;

    localparam int OSR_W = 32;

    typedef struct packed {
        logic empty;
        logic full;
    } fifo_status;

    typedef enum logic {
        OSR_IDLE = 1'b0,
        OSR_LOAD = 1'b1
    } osr_state_t;

endpackage

// File: rtl/pio_osr_shifter.sv
// Combinational shift step of the output shift register.
//   osr      in   current shift register contents
//   n        in   bits to shift, 0 encodes 32
//   dir      in   1: LSBs leave first (shift right), 0: MSBs leave first (shift left)
//   out_data out  bits shifted out, right-justified, zero-extended
//   osr_next out  register contents after the shift, vacated bits zero
//   n_eff    out  decoded shift amount 1..32
module pio_osr_shifter
    import pio_osr_pkg::*;
(
    input  logic [OSR_W-1:0] osr,
    input  logic [4:0]       n,
    input  logic             dir,
    output logic [OSR_W-1:0] out_data,
    output logic [OSR_W-1:0] osr_next,
    output logic [5:0]       n_eff
);

    always_comb begin
        n_eff = (n == 5'd0) ? 6'd32 : {1'b0, n};
        if (dir) begin
            // A logical shift by the full width yields zero, so n_eff==32
            // gives an all-ones mask and an empty register.
            out_data = osr & ~({OSR_W{1'b1}} << n_eff);
            osr_next = osr >> n_eff;
        end else begin
            out_data = osr >> (6'd32 - n_eff);
            osr_next = osr << n_eff;
        end
    end

endmodule

// File: rtl/pio_osr.sv
// Output shift register of a PIO state machine, downstream of the TX fifo.
// Words arrive by explicit PULL or autopull; OUT shifts 1..32 bits out.
//   clk, rst     clock; asynchronous active-high reset
//   fifo_data    TX fifo read data, valid the cycle after fifo_pop
//   fifo_stat    TX fifo empty/full flags
//   fifo_pop     pop strobe, only while the fifo is non-empty and in OSR_IDLE
//   out_req      OUT request, out_count bits (0 = 32)
//   pull_req     PULL request; pull_block selects stall vs. zero-load on empty
//   autopull_en  refill automatically once shift_cnt reaches the threshold
//   pull_thresh  autopull threshold (0 = RESET_THRESH)
//   shift_right  1: LSB first, 0: MSB first
//   out_data     shifted-out bits (zero for PULL completions), valid with out_valid
//   out_valid    one-cycle strobe: OUT or PULL completed this cycle
//   stall        current request cannot complete; the SM holds it
//   shift_cnt    bits consumed since last load, 0..32
//   state_dbg    current FSM state
// Optional build macro PIO_OSR_MOV_EN adds mov_load/mov_data, a direct
// register write from the state machine with top priority in OSR_IDLE.
//
// Handshake: a request is held by the SM while stall is high; it completes in
// the cycle where stall is low, and out_valid marks that cycle for OUT and
// PULL. out_valid and stall are combinational from state and requests.
module pio_osr
    import pio_osr_pkg::*;
#(
    parameter int RESET_THRESH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OSR_W-1:0] fifo_data,
    input  fifo_status       fifo_stat,
    output logic             fifo_pop,
    input  logic             out_req,
    input  logic [4:0]       out_count,
    input  logic             pull_req,
    input  logic             pull_block,
    input  logic             autopull_en,
    input  logic [4:0]       pull_thresh,
    input  logic             shift_right,
`ifdef PIO_OSR_MOV_EN
    input  logic             mov_load,
    input  logic [OSR_W-1:0] mov_data,
`endif
    output logic [OSR_W-1:0] out_data,
    output logic             out_valid,
    output logic             stall,
    output logic [5:0]       shift_cnt,
    output osr_state_t       state_dbg
);

    osr_state_t       state_q, state_d;
    logic [OSR_W-1:0] osr_q, osr_d;
    logic [5:0]       cnt_q, cnt_d;
    // Set while the pending load belongs to an explicit PULL, so the LOAD
    // cycle reports completion; autopull loads stay silent.
    logic             pend_q, pend_d;

    logic [OSR_W-1:0] sh_out, sh_next;
    logic [5:0]       n_eff;
    logic [5:0]       thresh;
    logic [6:0]       cnt_sum;
    logic [5:0]       cnt_sat;
    logic             need_refill;
    logic             mov_req;
    logic [OSR_W-1:0] mov_word;
    logic             unused_full;

    assign unused_full = fifo_stat.full;

`ifdef PIO_OSR_MOV_EN
    assign mov_req  = mov_load;
    assign mov_word = mov_data;
`else
    assign mov_req  = 1'b0;
    assign mov_word = '0;
`endif

    pio_osr_shifter u_shifter (
        .osr      (osr_q),
        .n        (out_count),
        .dir      (shift_right),
        .out_data (sh_out),
        .osr_next (sh_next),
        .n_eff    (n_eff)
    );

    assign thresh      = (pull_thresh == 5'd0) ? 6'(RESET_THRESH) : {1'b0, pull_thresh};
    assign need_refill = autopull_en && (cnt_q >= thresh);
    assign cnt_sum     = {1'b0, cnt_q} + {1'b0, n_eff};
    assign cnt_sat     = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

    always_comb begin
        state_d   = state_q;
        osr_d     = osr_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        fifo_pop  = 1'b0;
        out_valid = 1'b0;
        stall     = 1'b0;
        out_data  = '0;
        // Outputs are forced to their reset values while rst is held.
        if (!rst) begin
            case (state_q)
                OSR_IDLE: begin
                    if (mov_req) begin
                        osr_d = mov_word;
                        cnt_d = 6'd0;
                        stall = pull_req | out_req;
                    end else if (pull_req) begin
                        if (!fifo_stat.empty) begin
                            fifo_pop = 1'b1;
                            stall    = 1'b1;
                            pend_d   = 1'b1;
                            state_d  = OSR_LOAD;
                        end else if (pull_block) begin
                            stall = 1'b1;
                        end else begin
                            osr_d     = '0;
                            cnt_d     = 6'd0;
                            out_valid = 1'b1;
                        end
                    end else if (need_refill) begin
                        // OUT waits until the refill lands, even on an empty fifo.
                        stall = out_req;
                        if (!fifo_stat.empty) begin
                            fifo_pop = 1'b1;
                            pend_d   = 1'b0;
                            state_d  = OSR_LOAD;
                        end
                    end else if (out_req) begin
                        out_valid = 1'b1;
                        out_data  = sh_out;
                        osr_d     = sh_next;
                        cnt_d     = cnt_sat;
                    end
                end
                OSR_LOAD: begin
                    osr_d     = fifo_data;
                    cnt_d     = 6'd0;
                    pend_d    = 1'b0;
                    state_d   = OSR_IDLE;
                    out_valid = pend_q;
                    stall     = mov_req | (!pend_q & (pull_req | out_req));
                end
                default: state_d = OSR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OSR_IDLE;
            osr_q   <= '0;
            cnt_q   <= 6'd32;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            osr_q   <= osr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign shift_cnt = cnt_q;
    assign state_dbg = state_q;

endmodule
